regfile_master: RTL

//  Bus-side controller that drives the 8x16 register file's WrEn/RdEn/Address/WrData port and collects RdData.

---
 rtl/regfile_master.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_master.sv
// Bus-side master for the 8x16 register file: turns (addr, len, dir) commands
// into single/burst WrEn/RdEn accesses with wrapping address auto-increment.
module regfile_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RCAP, RSP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      // RdData is valid one cycle after the RdEn edge, i.e. while in RCAP
      if (state_q == RCAP) begin
        rsp_data_q <= RdData;
        rsp_last_q <= (beats_q == '0);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          beats_d = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        WrEn     = wr_valid;
        if (wr_valid) begin
          if (beats_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            beats_d = beats_q - LEN_W'(1);
          end
        end
      end
      READ: begin
        RdEn    = 1'b1;
        state_d = RCAP;
      end
      RCAP: state_d = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            beats_d = beats_q - LEN_W'(1);
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign Address  = addr_q;
  assign WrData   = wr_data;
  assign rsp_data = rsp_data_q;
  assign rsp_last = rsp_last_q;

endmodule
